// File: rtl/exu.sv
// Execution unit: single-cycle ALU ops plus an iterative 16x16 shift-add multiplier.
// Results, write-enable pulse and flags are registered; busy_out covers the multiply.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | accepts start_in; single-cycle ops complete on the start edge
// S_MUL  | one shift-add step per edge; result written on the 16th edge
module exu #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic [3:0]  op_in,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [15:0] d_out,
    output logic        rw_out,
    output logic        busy_out,
    output logic        z_out,
    output logic        n_out,
    output logic        c_out
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    state_t      state_q;
    state_t      state_d;

    logic [4:0]  cnt_q;
    logic [31:0] acc_q;
    logic [15:0] mcand_q;
    logic [15:0] mplier_q;

    logic [15:0] d_q;
    logic        rw_q;
    logic        z_q;
    logic        n_q;
    logic        c_q;

    logic [16:0] sum_w;
    logic [16:0] diff_w;
    logic [16:0] shl_w;
    logic [16:0] shr_w;
    logic [15:0] alu_res;
    logic        alu_c;

    logic [31:0] partial_w;
    logic [31:0] acc_next_w;
    logic        mul_last_w;

    logic [15:0] res_d;
    logic        c_d;
    logic        wr_en;
    logic        flag_en;
    logic        mul_load;
    logic        mul_step;

    // Widened shifts make the carry fall out as the extra bit; a zero shift yields carry 0.
    always_comb begin
        sum_w  = {1'b0, a_in} + {1'b0, b_in};
        diff_w = {1'b0, a_in} - {1'b0, b_in};
        shl_w  = {1'b0, a_in} << b_in[3:0];
        shr_w  = {a_in, 1'b0} >> b_in[3:0];
    end

    always_comb begin
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res = sum_w[15:0];
                alu_c   = sum_w[16];
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff_w[15:0];
                alu_c   = diff_w[16];
            end
            OP_AND: alu_res = a_in & b_in;
            OP_OR:  alu_res = a_in | b_in;
            OP_XOR: alu_res = a_in ^ b_in;
            OP_NOT: alu_res = ~a_in;
            OP_SHL: begin
                alu_res = shl_w[15:0];
                alu_c   = shl_w[16];
            end
            OP_SHR: begin
                alu_res = shr_w[16:1];
                alu_c   = shr_w[0];
            end
            OP_MOV: alu_res = b_in;
            default: begin
                alu_res = 16'h0000;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        partial_w  = mplier_q[cnt_q[3:0]] ? ({16'h0000, mcand_q} << cnt_q[3:0]) : 32'h0000_0000;
        acc_next_w = acc_q + partial_w;
        mul_last_w = (cnt_q == 5'd15);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        res_d    = alu_res;
        c_d      = alu_c;
        wr_en    = 1'b0;
        flag_en  = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (op_in <= OP_MOV) begin
                        wr_en   = 1'b1;
                        flag_en = 1'b1;
                    end else if (op_in == OP_CMP) begin
                        flag_en = 1'b1;
                    end else if ((op_in == OP_MUL) && MUL_EN) begin
                        mul_load = 1'b1;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                res_d    = acc_next_w[15:0];
                c_d      = |acc_next_w[31:16];
                if (mul_last_w) begin
                    wr_en   = 1'b1;
                    flag_en = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q      <= 16'h0000;
            rw_q     <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            cnt_q    <= 5'd0;
            acc_q    <= 32'h0000_0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
        end else begin
            rw_q <= wr_en;
            if (wr_en) begin
                d_q <= res_d;
            end
            if (flag_en) begin
                z_q <= (res_d == 16'h0000);
                n_q <= res_d[15];
                c_q <= c_d;
            end
            if (mul_load) begin
                mcand_q  <= a_in;
                mplier_q <= b_in;
                cnt_q    <= 5'd0;
                acc_q    <= 32'h0000_0000;
            end else if (mul_step) begin
                acc_q <= acc_next_w;
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign d_out    = d_q;
    assign rw_out   = rw_q;
    assign busy_out = (state_q == S_MUL);
    assign z_out    = z_q;
    assign n_out    = n_q;
    assign c_out    = c_q;

endmodule

// File: tb/tb_exu.sv
// Directed self-checking bench for exu: ALU ops, flags, iterative multiply, busy lockout, reset abort.
module tb_exu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [3:0]  op_in = 4'd0;
    logic [15:0] a_in = 16'h0000;
    logic [15:0] b_in = 16'h0000;
    logic [15:0] d_out;
    logic        rw_out;
    logic        busy_out;
    logic        z_out;
    logic        n_out;
    logic        c_out;

    int checks = 0;
    int errors = 0;

    exu #(.MUL_EN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start_in),
        .op_in    (op_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .d_out    (d_out),
        .rw_out   (rw_out),
        .busy_out (busy_out),
        .z_out    (z_out),
        .n_out    (n_out),
        .c_out    (c_out)
    );

    always #5 clk = ~clk;

    // Presents one start for a single edge; returns #1 after that edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start_in = 1'b1;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (d_out !== 16'h0000) begin errors++; $display("FAIL reset_d: got %h expected 0000", d_out); end
        checks++; if ({rw_out, busy_out, z_out, n_out, c_out} !== 5'b00000) begin errors++; $display("FAIL reset_ctl: got %b expected 00000", {rw_out, busy_out, z_out, n_out, c_out}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        issue(4'd0, 16'hFFFF, 16'h0001);
        checks++; if (d_out !== 16'h0000) begin errors++; $display("FAIL add_d: got %h expected 0000", d_out); end
        checks++; if ({rw_out, z_out, n_out, c_out} !== 4'b1101) begin errors++; $display("FAIL add_flags: rw/z/n/c got %b expected 1101", {rw_out, z_out, n_out, c_out}); end
        @(posedge clk); #1;
        checks++; if (rw_out !== 1'b0 || d_out !== 16'h0000) begin errors++; $display("FAIL add_hold: rw %b d %h expected rw 0 d 0000", rw_out, d_out); end
    endtask

    task automatic test_sub_cmp();
        issue(4'd1, 16'h0003, 16'h0005);
        checks++; if (d_out !== 16'hFFFE) begin errors++; $display("FAIL sub_d: got %h expected fffe", d_out); end
        checks++; if ({rw_out, z_out, n_out, c_out} !== 4'b1011) begin errors++; $display("FAIL sub_flags: rw/z/n/c got %b expected 1011", {rw_out, z_out, n_out, c_out}); end
        issue(4'd10, 16'h0003, 16'h0005);
        checks++; if (d_out !== 16'hFFFE) begin errors++; $display("FAIL cmp_d: got %h expected fffe", d_out); end
        checks++; if ({rw_out, z_out, n_out, c_out} !== 4'b0011) begin errors++; $display("FAIL cmp_flags: rw/z/n/c got %b expected 0011", {rw_out, z_out, n_out, c_out}); end
        issue(4'd10, 16'h0005, 16'h0005);
        checks++; if ({d_out, rw_out, z_out, n_out, c_out} !== {16'hFFFE, 4'b0100}) begin errors++; $display("FAIL cmp_eq: d %h rw/z/n/c %b expected fffe 0100", d_out, {rw_out, z_out, n_out, c_out}); end
    endtask

    task automatic test_shift();
        issue(4'd6, 16'h8001, 16'h0001);
        checks++; if ({d_out, rw_out, c_out} !== {16'h0002, 2'b11}) begin errors++; $display("FAIL shl1: d %h rw/c %b expected 0002 11", d_out, {rw_out, c_out}); end
        issue(4'd7, 16'h0002, 16'h0000);
        checks++; if ({d_out, rw_out, z_out, n_out, c_out} !== {16'h0002, 4'b1000}) begin errors++; $display("FAIL shr0: d %h rw/z/n/c %b expected 0002 1000", d_out, {rw_out, z_out, n_out, c_out}); end
        issue(4'd7, 16'h800F, 16'h0004);
        checks++; if ({d_out, c_out} !== {16'h0800, 1'b1}) begin errors++; $display("FAIL shr4: d %h c %b expected 0800 1", d_out, c_out); end
        issue(4'd6, 16'h800F, 16'h000F);
        checks++; if ({d_out, n_out, c_out} !== {16'h8000, 2'b11}) begin errors++; $display("FAIL shl15: d %h n/c %b expected 8000 11", d_out, {n_out, c_out}); end
    endtask

    task automatic test_logic();
        logic [3:0]  ops [5]  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
        logic [15:0] av  [5]  = '{16'hF0F0, 16'h00F0, 16'hAAAA, 16'h00FF, 16'h5555};
        logic [15:0] bv  [5]  = '{16'hFF00, 16'h0F00, 16'hAAAA, 16'h1234, 16'h1234};
        logic [15:0] ev  [5]  = '{16'hF000, 16'h0FF0, 16'h0000, 16'hFF00, 16'h1234};
        logic [3:0]  ef  [5]  = '{4'b1010, 4'b1000, 4'b1100, 4'b1010, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], av[i], bv[i]);
            checks++;
            if ({d_out, rw_out, z_out, n_out, c_out} !== {ev[i], ef[i]}) begin
                errors++;
                $display("FAIL logic_op%0d: d %h rw/z/n/c %b expected %h %b", ops[i], d_out, {rw_out, z_out, n_out, c_out}, ev[i], ef[i]);
            end
        end
    endtask

    task automatic test_nop();
        issue(4'd0, 16'h7FFF, 16'h0001);
        checks++; if ({d_out, z_out, n_out, c_out} !== {16'h8000, 3'b010}) begin errors++; $display("FAIL nop_pre: d %h z/n/c %b expected 8000 010", d_out, {z_out, n_out, c_out}); end
        issue(4'd12, 16'h0000, 16'h0000);
        checks++; if ({d_out, rw_out, z_out, n_out, c_out} !== {16'h8000, 4'b0010}) begin errors++; $display("FAIL nop12: d %h rw/z/n/c %b expected 8000 0010", d_out, {rw_out, z_out, n_out, c_out}); end
        issue(4'd15, 16'hFFFF, 16'hFFFF);
        checks++; if ({d_out, rw_out, z_out, n_out, c_out} !== {16'h8000, 4'b0010}) begin errors++; $display("FAIL nop15: d %h rw/z/n/c %b expected 8000 0010", d_out, {rw_out, z_out, n_out, c_out}); end
    endtask

    task automatic test_mul();
        logic [15:0] av [2] = '{16'h0123, 16'h1000};
        logic [15:0] bv [2] = '{16'h0045, 16'h0010};
        logic [15:0] ev [2] = '{16'h4E6F, 16'h0000};
        logic [2:0]  ef [2] = '{3'b000, 3'b101};
        for (int k = 0; k < 2; k++) begin
            int busy_cycles;
            int bad_rw;
            issue(4'd9, av[k], bv[k]);
            busy_cycles = 0;
            bad_rw = 0;
            for (int i = 1; i <= 16; i++) begin
                if (busy_out === 1'b1) busy_cycles++;
                if (rw_out !== 1'b0) bad_rw++;
                @(posedge clk); #1;
            end
            checks++; if (busy_cycles != 16 || bad_rw != 0) begin errors++; $display("FAIL mul%0d_busy: busy cycles %0d early rw %0d expected 16 0", k, busy_cycles, bad_rw); end
            checks++; if ({busy_out, rw_out} !== 2'b01) begin errors++; $display("FAIL mul%0d_done: busy/rw %b expected 01", k, {busy_out, rw_out}); end
            checks++; if ({d_out, z_out, n_out, c_out} !== {ev[k], ef[k]}) begin errors++; $display("FAIL mul%0d_res: d %h z/n/c %b expected %h %b", k, d_out, {z_out, n_out, c_out}, ev[k], ef[k]); end
            @(posedge clk); #1;
            checks++; if (rw_out !== 1'b0) begin errors++; $display("FAIL mul%0d_pulse: rw %b expected 0", k, rw_out); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int pulse_cyc = -1;
        logic [15:0] pulse_d = 16'h0000;
        issue(4'd9, 16'h0007, 16'h0009);
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                @(negedge clk);
                start_in = 1'b1;
                op_in    = 4'd0;
                a_in     = 16'hFFFF;
                b_in     = 16'h0001;
            end
            @(posedge clk); #1;
            start_in = 1'b0;
            if (rw_out === 1'b1) begin
                pulses++;
                pulse_cyc = i;
                pulse_d = d_out;
            end
        end
        checks++; if (pulses != 1 || pulse_cyc != 16) begin errors++; $display("FAIL busy_start_pulses: %0d pulses at cycle %0d expected 1 at 16", pulses, pulse_cyc); end
        checks++; if (pulse_d !== 16'h003F || d_out !== 16'h003F) begin errors++; $display("FAIL busy_start_d: pulse d %h final d %h expected 003f", pulse_d, d_out); end
        issue(4'd0, 16'h0010, 16'h0020);
        checks++; if ({d_out, rw_out} !== {16'h0030, 1'b1}) begin errors++; $display("FAIL after_mul_add: d %h rw %b expected 0030 1", d_out, rw_out); end
    endtask

    task automatic test_reset_mid_mul();
        int pulses = 0;
        issue(4'd9, 16'h0123, 16'h0045);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (d_out !== 16'h0000) begin errors++; $display("FAIL rst_mul_d: got %h expected 0000", d_out); end
        checks++; if ({rw_out, busy_out, z_out, n_out, c_out} !== 5'b00000) begin errors++; $display("FAIL rst_mul_ctl: got %b expected 00000", {rw_out, busy_out, z_out, n_out, c_out}); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rw_out !== 1'b0) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rw_out !== 1'b0 || busy_out !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mul_pulse: %0d stray rw/busy cycles expected 0", pulses); end
        issue(4'd0, 16'h0002, 16'h0003);
        checks++; if ({d_out, rw_out, busy_out, z_out, n_out, c_out} !== {16'h0005, 5'b10000}) begin errors++; $display("FAIL rst_add: d %h rw/busy/z/n/c %b expected 0005 10000", d_out, {rw_out, busy_out, z_out, n_out, c_out}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_shift();
        test_logic();
        test_nop();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
